// File: rtl/multicycle_datapath_if.sv
// Shared memory port of the multicycle datapath. Instruction fetches and data
// accesses both use this one port.
//   adr        : byte address driven by the datapath (combinational)
//   write_data : store data, taken from the B register
//   read_data  : data returned by memory
//   mem_ready  : 1 = the memory cycle completes this edge, 0 = stall
// The datapath connects through the master modport and memory through the
// slave modport.
interface multicycle_datapath_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic             mem_ready;

  modport master (
    output adr,
    output write_data,
    input  read_data,
    input  mem_ready
  );

  modport slave (
    input  adr,
    input  write_data,
    output read_data,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle ARM-subset datapath. An external controller sequences the
// architectural registers (PC, IR, Data, A, B, ALUOut, NZCV), which share a
// single memory port for instructions and data. When the memory reports
// "not ready", every piece of state, including register-file writes, is frozen.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   pc_write     load PC with Result
//   adr_src      address select: 0 PC, 1 Result
//   ir_write     load IR with read data
//   reg_src      [0] RA1 = 15 else instr[19:16]; [1] RA2 = instr[15:12] else instr[3:0]
//   reg_write    write Result to R[instr[15:12]] (R15 writes are dropped)
//   imm_src      immediate extend mode
//   alu_src_a    SrcA: 0 A, 1 PC
//   alu_src_b    SrcB: 00 B, 01 ExtImm, 1x constant 4
//   alu_control  00 ADD, 01 SUB, 10 AND, 11 ORR
//   result_src   Result: 00 ALUOut, 01 Data, 1x ALUResult
//   flag_w       [1] update N,Z; [0] update C,V
//   bus          memory port (adr, write_data, read_data, mem_ready)
//   instr        IR contents
//   flags        registered {N,Z,C,V}
//   pc           program counter
module multicycle_datapath #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pc_write,
  input  logic                      adr_src,
  input  logic                      ir_write,
  input  logic [1:0]                reg_src,
  input  logic                      reg_write,
  input  logic [1:0]                imm_src,
  input  logic                      alu_src_a,
  input  logic [1:0]                alu_src_b,
  input  logic [1:0]                alu_control,
  input  logic [1:0]                result_src,
  input  logic [1:0]                flag_w,
  multicycle_datapath_if.master     bus,
  output logic [31:0]               instr,
  output logic [3:0]                flags,
  output logic [WIDTH-1:0]          pc
);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // architectural state
  logic [WIDTH-1:0] pc_q;
  logic [31:0]      ir_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] alu_out_q;
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] rf [0:14];

  // combinational datapath
  logic [WIDTH-1:0] pc_plus4;
  logic [3:0]       ra1;
  logic [3:0]       ra2;
  logic [3:0]       wa;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] ext_imm;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_result;
  logic             alu_c;
  logic             alu_v;
  logic [3:0]       alu_flags;
  logic [WIDTH-1:0] result;

  assign pc_plus4 = pc_q + WIDTH'(4);

  // register file addressing
  assign ra1 = reg_src[0] ? 4'd15 : ir_q[19:16];
  assign ra2 = reg_src[1] ? ir_q[15:12] : ir_q[3:0];
  assign wa  = ir_q[15:12];

  // R15 is not stored; reading it yields PC+4, which is the fetched
  // instruction's address + 8 once the fetch has advanced PC.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 == 4'd15) rd1 = pc_plus4;
    else              rd1 = rf[ra1];
    if (ra2 == 4'd15) rd2 = pc_plus4;
    else              rd2 = rf[ra2];
  end

  // immediate extension
  always_comb begin
    ext_imm = '0;
    case (imm_src)
      2'b00:   ext_imm = {{(WIDTH-8){1'b0}}, ir_q[7:0]};
      2'b01:   ext_imm = {{(WIDTH-12){1'b0}}, ir_q[11:0]};
      2'b10:   ext_imm = {{(WIDTH-26){ir_q[23]}}, ir_q[23:0], 2'b00};
      default: ext_imm = '0;
    endcase
  end

  // ALU operand selection
  always_comb begin
    src_a = alu_src_a ? pc_q : a_q;
    src_b = '0;
    case (alu_src_b)
      2'b00:   src_b = b_q;
      2'b01:   src_b = ext_imm;
      default: src_b = WIDTH'(4);
    endcase
  end

  // ALU. Subtraction is done as SrcA + ~SrcB + 1 so that the carry out is
  // the ARM "no borrow" flag; overflow is judged on the operand actually
  // presented to the adder.
  always_comb begin
    b_op       = (alu_control == ALU_SUB) ? ~src_b : src_b;
    sum        = {1'b0, src_a} + {1'b0, b_op}
               + {{WIDTH{1'b0}}, (alu_control == ALU_SUB)};
    alu_result = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (alu_control)
      ALU_ADD, ALU_SUB: begin
        alu_result = sum[WIDTH-1:0];
        alu_c      = sum[WIDTH];
        alu_v      = (src_a[WIDTH-1] == b_op[WIDTH-1]) &&
                     (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      ALU_AND: alu_result = src_a & src_b;
      ALU_ORR: alu_result = src_a | src_b;
      default: alu_result = '0;
    endcase
    alu_flags = {alu_result[WIDTH-1], (alu_result == '0), alu_c, alu_v};
  end

  // result selection
  always_comb begin
    result = '0;
    case (result_src)
      2'b00:   result = alu_out_q;
      2'b01:   result = data_q;
      default: result = alu_result;
    endcase
  end

  // State update. Reset wins over everything; mem_ready == 0 freezes all
  // state, so the controller can simply hold its controls through a wait.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      data_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      flags_q   <= '0;
      for (int i = 0; i < 15; i++) begin
        rf[i] <= '0;
      end
    end else if (bus.mem_ready) begin
      a_q       <= rd1;
      b_q       <= rd2;
      data_q    <= bus.read_data;
      alu_out_q <= alu_result;
      if (ir_write) ir_q <= bus.read_data[31:0];
      if (pc_write) pc_q <= result;
      if (reg_write && (wa != 4'd15)) rf[wa] <= result;
      if (flag_w[1]) flags_q[3:2] <= alu_flags[3:2];
      if (flag_w[0]) flags_q[1:0] <= alu_flags[1:0];
    end
  end

  assign bus.adr        = adr_src ? result : pc_q;
  assign bus.write_data = b_q;
  assign instr          = ir_q;
  assign flags          = flags_q;
  assign pc             = pc_q;

endmodule
